// File: rtl/tree_adder_pkg.sv
// Shared definitions for the tree adder and its input packer: packer state
// encoding, lane-count derivation and lane-slice helpers, so that both blocks
// agree on which bits of the wide vector belong to which lane.
package tree_adder_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  // Default geometry of the tree adder datapath
  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;

  // Number of lanes for a tree of depth n
  function automatic int lanes(input int n);
    return 2 ** n;
  endfunction

  localparam int L_DEF = lanes(N_DEF);

  // Lowest bit of lane k in a vector of dw-bit lanes
  function automatic int lane_lo(input int k, input int dw);
    return k * dw;
  endfunction

  // Highest bit of lane k in a vector of dw-bit lanes
  function automatic int lane_hi(input int k, input int dw);
    return (k + 1) * dw - 1;
  endfunction

endpackage

// File: rtl/tree_adder_input_packer_if.sv
// Handshake bundle between the sample source, the packer and the tree adder.
// The master modport is the environment side (sample source and window sink),
// the slave modport is the packer itself.
// Optional macro TREE_PACK_FLUSH_EN adds the flush request line.
interface tree_adder_input_packer_if #(
  parameter int N  = 4,
  parameter int DW = 8
);

  localparam int L = 2 ** N;

  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [L*DW-1:0] out_data;
`ifdef TREE_PACK_FLUSH_EN
  logic            flush;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
`endif

endinterface

// File: rtl/tree_adder_input_packer.sv
// Packs 2^N consecutive DW-bit samples into one wide lane vector for the tree
// adder. A fill register collects the current window while the output
// register presents the previous one, so one full extra window can be parked
// (HOLD) under backpressure before in_ready drops.
// Optional macro TREE_PACK_FLUSH_EN: adds a flush input that closes a partial
// window early; unfilled lanes are zero so the tree sum stays correct.
module tree_adder_input_packer
  import tree_adder_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  tree_adder_input_packer_if.slave bus
);

  localparam int L = lanes(N);

  pack_state_t     state;
  logic [N-1:0]    cnt;
  logic [L*DW-1:0] fill;

  logic            in_beat;
  logic            slot_free;
  logic            flush_close;
  logic            close;
  logic [L*DW-1:0] win;

  // Accept samples only while collecting, never during reset
  assign bus.in_ready = rst_n && (state == FILL);

  // Window as it would look after this edge's sample, and close decision
  always_comb begin
    in_beat   = bus.in_valid && bus.in_ready;
    slot_free = !bus.out_valid || bus.out_ready;
    win       = fill;
    for (int k = 0; k < L; k++) begin
      if (in_beat && (cnt == N'(k))) begin
        win[lane_lo(k, DW) +: DW] = bus.in_data;
      end
    end
    flush_close = 1'b0;
`ifdef TREE_PACK_FLUSH_EN
    if ((state == FILL) && bus.flush && ((cnt != '0) || in_beat)) begin
      flush_close = 1'b1;
    end
`endif
    close = (in_beat && (&cnt)) || flush_close;
  end

  // FSM, fill register and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      cnt           <= '0;
      fill          <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      // A consumed window empties the slot unless a new one replaces it below
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      case (state)
        FILL: begin
          if (close) begin
            cnt <= '0;
            if (slot_free) begin
              bus.out_data  <= win;
              bus.out_valid <= 1'b1;
              fill          <= '0;
            end else begin
              fill  <= win;
              state <= HOLD;
            end
          end else if (in_beat) begin
            fill <= win;
            cnt  <= cnt + N'(1);
          end
        end
        HOLD: begin
          if (slot_free) begin
            bus.out_data  <= fill;
            bus.out_valid <= 1'b1;
            fill          <= '0;
            cnt           <= '0;
            state         <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/tree_adder_input_packer.md
# tree_adder_input_packer

Upstream feeder for the balanced tree adder. It accepts one DW-bit sample per handshake beat and packs 2^N consecutive samples into the adder's wide lane vector. It presents each full window with a valid/ready handshake and holds it stable under backpressure. A second window buffer lets filling continue while the previous window waits downstream.

## Interface
- N, 4, log2 of lanes per window; L = 2^N; N >= 1
- DW, 8, sample width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample present
- in_ready  out  1  packer can accept a sample
- in_data  in  DW  sample
- out_valid  out  1  packed window present
- out_ready  in  1  downstream accepts window
- out_data  out  L*DW  packed window; lane k (0-based) at bits [(k+1)*DW-1 : k*DW]
- flush  in  1  close partial window (present only with TREE_PACK_FLUSH_EN)

## Operation
- Beats: input beat = in_valid && in_ready at a clk edge; output beat = out_valid && out_ready at a clk edge.
- Storage:
  - Fill register: L lanes plus an N-bit lane counter `cnt`.
  - Output register: L lanes plus out_valid.
- FSM has two states, FILL and HOLD.
  - In FILL, in_ready = 1 (gated to 0 while rst_n is low).
    - An input beat writes in_data to fill lane `cnt`, then `cnt` increments and wraps naturally at L.
    - If the beat fills lane L-1 and the output slot is free (!out_valid || out_ready), then at that edge out_data <= the fill lanes with lane L-1 = in_data, out_valid <= 1, cnt <= 0, and the FSM stays in FILL.
    - If the beat fills lane L-1 and the slot is occupied, lane L-1 is stored in the fill register and the FSM goes to HOLD.
  - In HOLD, in_ready = 0. When the slot frees (!out_valid || out_ready), out_data <= fill lanes, out_valid <= 1, cnt <= 0, and the FSM goes to FILL.
- Output beat with no new window transferring in the same edge: out_valid <= 0, and out_data keeps its last value.
- Simultaneous output beat and window transfer: out_valid stays 1 and out_data takes the new window. There is no bubble.
- Lane order: the first sample of a window lands in lane 0.
- No arithmetic is performed. Data bits pass through unchanged.

## Timing
- Reset (async assert, sync release): state FILL, cnt 0, all fill lanes 0, out_data 0, out_valid 0, in_ready 0 while rst_n is low.
- Latency: the last sample is accepted at edge t and out_valid is high from edge t onward. Output latency is 0 cycles after the last beat.
- Throughput: 1 sample/cycle sustained while out_ready = 1.
- Under backpressure, up to one full extra window is buffered before in_ready drops.
- Stability: while out_valid && !out_ready, out_data and out_valid must not change.
- in_ready depends only on state, never combinationally on out_ready.
- Reset mid-window or mid-HOLD discards all buffered samples.

## Configuration
- Macro: TREE_PACK_FLUSH_EN.
- Defined: the flush port exists.
  - In FILL with flush = 1, the window closes if cnt > 0 or a sample is accepted in that cycle. The same-cycle sample is included.
  - Unfilled lanes are zero (tree sum stays correct).
  - The closed window transfers under the same free/occupied rules as a full window: it goes to the output register, or to HOLD if the slot is occupied.
  - flush is ignored when cnt = 0 with no input beat, and ignored in HOLD.
- Undefined: there is no flush port, and windows close only when full.

## Structure
- Shared package tree_adder_pkg:
  - Packer state enum (FILL, HOLD).
  - Lane-count localparam L = 2**N as a function of N.
  - Lane-slice helper constants shared with the tree adder so that both blocks use identical lane indexing.
- Single flat module; no sub-module is warranted.

## Test plan
All scenarios use N=2, DW=8.
- Basic pack: samples 01,02,03,04 on consecutive cycles with out_ready=1 -> out_valid high after the 4th edge for 1 cycle, out_data=32'h04030201.
- Streaming: 8 samples 10..17 back-to-back with out_ready=1 -> two windows, 32'h13121110 then 32'h17161514, with in_ready constantly 1.
- Backpressure:
  - Stimulus: out_ready=0, 8 samples A0..A7.
  - Window 32'hA3A2A1A0 holds stable, and second window A7..A4 goes to HOLD with in_ready=0.
  - Then out_ready=1 for 2 cycles -> both windows delivered in order with no bubble.
- Reset mid-window: 2 samples, then rst_n low for 1 cycle -> out_valid=0, out_data=0. Next 4 samples 05..08 -> 32'h08070605.
- Flush (macro on):
  - Samples 11,22 then flush alone -> 32'h00002211.
  - Flush with 3rd sample 33 in the same cycle -> 32'h00332211.
